// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the combinational program ROM: fetch (F) vs debug/loader (D).
// Optional macro ROM_ARB_FETCH_PRIO_EN: fetch-priority ties with a bounded debug wait.
module rom_port_arbiter #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              f_stall,
   output logic [CNT_W-1:0]  conflict_cnt
);

   if (MAX_WAIT < 1) begin : g_max_wait_check
      $error("rom_port_arbiter: MAX_WAIT must be at least 1");
   end

   logic              w_f_gnt;
   logic              w_d_gnt;
   logic              w_tie;
   logic              w_tie_to_d;
   logic              r_f_rvalid;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_conflict_cnt;

   assign w_tie = f_req && d_req;

`ifdef ROM_ARB_FETCH_PRIO_EN
   localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [WaitW-1:0] r_wait_cnt;
   logic             r_d_boost;

   // Once D has waited MAX_WAIT cycles, the boost flag hands it the following tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_d_boost  <= 1'b0;
      end else if (!d_req || w_d_gnt) begin
         r_wait_cnt <= '0;
         r_d_boost  <= 1'b0;
      end else if (r_wait_cnt == WaitW'(MAX_WAIT)) begin
         r_d_boost  <= 1'b1;
      end else begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_tie_to_d = r_d_boost;
`else
   typedef enum logic {
      PortF = 1'b0,
      PortD = 1'b1
   } port_e;

   port_e r_last_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_gnt <= PortD;
      end else if (w_f_gnt) begin
         r_last_gnt <= PortF;
      end else if (w_d_gnt) begin
         r_last_gnt <= PortD;
      end
   end

   assign w_tie_to_d = (r_last_gnt == PortF);
`endif

   always_comb begin
      w_f_gnt = 1'b0;
      w_d_gnt = 1'b0;
      unique case ({f_req, d_req})
         2'b10:   w_f_gnt = 1'b1;
         2'b01:   w_d_gnt = 1'b1;
         2'b11: begin
            w_d_gnt = w_tie_to_d;
            w_f_gnt = !w_tie_to_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_f_rvalid <= w_f_gnt;
         r_d_rvalid <= w_d_gnt;
         if (w_f_gnt || w_d_gnt) begin
            r_rdata <= rom_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
      end else if (w_tie && (r_conflict_cnt != {CNT_W{1'b1}})) begin
         r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
   end

   // Idle cycles still present the fetch address to the ROM.
   assign rom_addr     = w_d_gnt ? d_addr : f_addr;
   assign f_gnt        = w_f_gnt;
   assign d_gnt        = w_d_gnt;
   assign f_stall      = f_req && !w_f_gnt;
   assign f_rvalid     = r_f_rvalid;
   assign d_rvalid     = r_d_rvalid;
   assign rdata        = r_rdata;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed, table-driven bench for rom_port_arbiter (default build, CNT_W=4).
module tb_rom_port_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rvalid;
   logic          d_req;
   logic [AW-1:0] d_addr;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          f_stall;
   logic [CW-1:0] conflict_cnt;

   logic [DW-1:0] rom [32];

   int n_tests = 0;
   int n_fail  = 0;

   rom_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .CNT_W   (CW),
      .MAX_WAIT(4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_req       (f_req),
      .f_addr      (f_addr),
      .f_gnt       (f_gnt),
      .f_rvalid    (f_rvalid),
      .d_req       (d_req),
      .d_addr      (d_addr),
      .d_gnt       (d_gnt),
      .d_rvalid    (d_rvalid),
      .rdata       (rdata),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .f_stall     (f_stall),
      .conflict_cnt(conflict_cnt)
   );

   assign rom_data = rom[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          f_req;
      logic [AW-1:0] f_addr;
      logic          d_req;
      logic [AW-1:0] d_addr;
      logic          e_fg;
      logic          e_dg;
      logic          e_st;
      logic [AW-1:0] e_ra;
      logic          e_frv;
      logic          e_drv;
      logic [DW-1:0] e_rd;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic fr, input logic [AW-1:0] fa,
                         input logic dr, input logic [AW-1:0] da);
      f_req  = fr;
      f_addr = fa;
      d_req  = dr;
      d_addr = da;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 | i;
      rom[0] = 32'h3463_0010;
      rom[1] = 32'hac03_0000;

      //           fr    fa    dr    da    fg    dg    st    ra    frv   drv   rdata          cnt
      vecs[0]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h3463_0010, 4'd0};
      vecs[1]  = '{1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 32'hac03_0000, 4'd0};
      vecs[2]  = '{1'b0, 5'd3, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 32'hac03_0000, 4'd0};
      vecs[3]  = '{1'b0, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 32'hac03_0000, 4'd0};
      vecs[4]  = '{1'b0, 5'd5, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 32'hac03_0000, 4'd0};
      vecs[5]  = '{1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h3463_0010, 4'd1};
      vecs[6]  = '{1'b1, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 32'hac03_0000, 4'd2};
      vecs[7]  = '{1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h3463_0010, 4'd3};
      vecs[8]  = '{1'b1, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 32'hac03_0000, 4'd4};
      vecs[9]  = '{1'b1, 5'd3, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 32'hA500_0003, 4'd4};
      vecs[10] = '{1'b0, 5'd6, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b1, 32'hA500_0004, 4'd4};

      rst_n = 1'b0;
      set_in(1'b0, 5'd0, 1'b0, 5'd0);
      #12;
      chk("reset f_rvalid", {31'd0, f_rvalid}, 32'd0);
      chk("reset d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset conflict_cnt", {28'd0, conflict_cnt}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         set_in(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_addr);
         #4;
         chk($sformatf("v%0d f_gnt", i), {31'd0, f_gnt}, {31'd0, vecs[i].e_fg});
         chk($sformatf("v%0d d_gnt", i), {31'd0, d_gnt}, {31'd0, vecs[i].e_dg});
         chk($sformatf("v%0d f_stall", i), {31'd0, f_stall}, {31'd0, vecs[i].e_st});
         chk($sformatf("v%0d rom_addr", i), {27'd0, rom_addr}, {27'd0, vecs[i].e_ra});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d f_rvalid", i), {31'd0, f_rvalid}, {31'd0, vecs[i].e_frv});
         chk($sformatf("v%0d d_rvalid", i), {31'd0, d_rvalid}, {31'd0, vecs[i].e_drv});
         chk($sformatf("v%0d rdata", i), rdata, vecs[i].e_rd);
         chk($sformatf("v%0d conflict_cnt", i), {28'd0, conflict_cnt}, {28'd0, vecs[i].e_cnt});
      end

      // Async reset between the grant edge and the valid cycle.
      set_in(1'b1, 5'd1, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      chk("pre-reset f_rvalid", {31'd0, f_rvalid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset f_rvalid", {31'd0, f_rvalid}, 32'd0);
      chk("midreset d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("midreset rdata", rdata, 32'd0);
      chk("midreset conflict_cnt", {28'd0, conflict_cnt}, 32'd0);
      set_in(1'b0, 5'd0, 1'b0, 5'd0);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset f_rvalid", {31'd0, f_rvalid}, 32'd0);
      chk("post-reset d_rvalid", {31'd0, d_rvalid}, 32'd0);

      // First tie after reset goes to F.
      set_in(1'b1, 5'd0, 1'b1, 5'd1);
      #4;
      chk("tie after reset f_gnt", {31'd0, f_gnt}, 32'd1);
      chk("tie after reset d_gnt", {31'd0, d_gnt}, 32'd0);
      @(posedge clk);
      #1;
      chk("tie after reset rdata", rdata, 32'h3463_0010);
      chk("tie after reset cnt", {28'd0, conflict_cnt}, 32'd1);

      // Hold the tie 20 more cycles: counter must stick at all-ones.
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
      end
      #1;
      chk("saturate cnt", {28'd0, conflict_cnt}, 32'h0000_000F);
      @(posedge clk);
      #1;
      chk("saturate hold cnt", {28'd0, conflict_cnt}, 32'h0000_000F);

      // Withdrawn D request produces no response.
      set_in(1'b0, 5'd2, 1'b0, 5'd1);
      @(posedge clk);
      #1;
      set_in(1'b0, 5'd2, 1'b1, 5'd3);
      #4;
      set_in(1'b0, 5'd2, 1'b0, 5'd3);
      #1;
      chk("withdraw d_gnt", {31'd0, d_gnt}, 32'd0);
      @(posedge clk);
      #1;
      chk("withdraw d_rvalid", {31'd0, d_rvalid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single 32x32 program ROM between two requesters: instruction fetch (port F) and debug/loader readback (port D).
- The ROM's read path is combinational. This block selects one address per cycle, registers the returned word and delivers it with a one-cycle valid pulse.
- Sits between the PC/fetch stage, the debug interface and the rom instance. Also keeps a saturating contention counter for bring-up.

Parameters:
- ADDR_W, 5, ROM word-address width.
- DATA_W, 32, ROM word width.
- CNT_W, 16, width of the contention counter.
- MAX_WAIT, 4, starvation limit for port D; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch data valid (registered, one-cycle pulse).
- d_req  in  1  debug read request.
- d_addr  in  ADDR_W  debug word address.
- d_gnt  out  1  debug granted this cycle (combinational).
- d_rvalid  out  1  debug data valid (registered, one-cycle pulse).
- rdata  out  DATA_W  registered ROM word; qualified by f_rvalid or d_rvalid.
- rom_addr  out  ADDR_W  address driven to the ROM.
- rom_data  in  DATA_W  ROM output word.
- f_stall  out  1  f_req && !f_gnt; the fetch stage freezes the PC on this.
- conflict_cnt  out  CNT_W  count of cycles with f_req && d_req; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - f_rvalid=0, d_rvalid=0, rdata=0, conflict_cnt=0.
  - last_gnt pointer = D, so F wins the first tie.
  - With the optional feature: wait_cnt=0.
- Grant is combinational and one-hot; at most one port per cycle.
  - Only F requests: F granted.
  - Only D requests: D granted.
  - Both request: the port not equal to last_gnt is granted (round-robin).
  - Neither requests: no grant.
- rom_addr:
  - d_addr when D is granted.
  - Otherwise f_addr, including when idle, so an idle ROM shows the fetch address.
- Latency:
  - Grant in cycle N; rom_data is captured into rdata at the end of cycle N.
  - The matching *_rvalid is high for exactly cycle N+1.
  - Back-to-back grants give back-to-back valids, one per cycle.
- rdata holds its value when no grant occurs.
- Requester rules:
  - Hold req and addr stable until gnt.
  - Address changes while not granted are legal; the address sampled is the one present in the grant cycle.
  - Dropping req before gnt withdraws the request; no response is produced.
- last_gnt updates only on a grant cycle, to the granted port.
- conflict_cnt increments by 1 in every cycle with f_req && d_req, unconditionally otherwise. At all-ones it holds.
- Reset mid-transaction: a pending rvalid is squashed; no response is delivered after rst_n rises.
- f_stall = f_req && !f_gnt, purely combinational.

Optional Feature:
- Macro: ROM_ARB_FETCH_PRIO_EN.
- Defined:
  - On ties, F is granted by fixed priority.
  - wait_cnt (width sufficient for MAX_WAIT) increments each cycle d_req && !d_gnt, and clears on d_gnt or when d_req is low.
  - When wait_cnt == MAX_WAIT, D wins the next tie. This bounds D latency to MAX_WAIT+1 cycles under continuous fetch.
  - last_gnt is unused.
- Undefined: pure round-robin as specified above; no wait_cnt register.

Test Plan:
- Fetch-only stream: ROM words 0/1 = 32'h34630010/32'hac030000, f_req=1, f_addr 0 then 1, d_req=0 -> f_gnt=1 both cycles; f_rvalid high in cycles 2–3; rdata 32'h34630010 then 32'hac030000; f_stall=0 throughout.
- Tie after reset: f_req=d_req=1, f_addr=0, d_addr=1 for 4 cycles -> grants alternate F,D,F,D; rdata alternates 32'h34630010/32'hac030000; conflict_cnt=4; f_stall=1 on D-granted cycles.
- Debug only, idle gaps: d_req pulse at d_addr=1, then 2 idle cycles -> single d_rvalid one cycle after grant; rdata=32'hac030000 held through the idle cycles; rom_addr tracks f_addr while idle.
- Async reset mid-flight: assert rst_n=0 between the grant edge and the valid cycle -> f_rvalid/d_rvalid=0, rdata=0, conflict_cnt=0 immediately; after release, a tie grants F first.
- Counter saturation: CNT_W=4, hold both requests 20 cycles -> conflict_cnt reaches 4'hF and stays.
- ROM_ARB_FETCH_PRIO_EN defined, MAX_WAIT=4, both requests held continuously -> F granted 5 consecutive cycles, D granted on cycle 6, then F resumes priority.
